// File: rtl/mouse_setup_ctrl_if.sv
// Value bus, write strobes and request inputs of the mouse setup sequencer.
// master = sequencer side, slave = mouse core / game logic side.
interface mouse_setup_ctrl_if;
   logic        recenter_req;
   logic        warp_req;
   logic [11:0] warp_x;
   logic [11:0] warp_y;
   logic [11:0] value;
   logic        setmax_x;
   logic        setmax_y;
   logic        setx;
   logic        sety;
   logic        ready;
   logic        done;

   modport master (
      input  recenter_req, warp_req, warp_x, warp_y,
      output value, setmax_x, setmax_y, setx, sety, ready, done
   );

   modport slave (
      output recenter_req, warp_req, warp_x, warp_y,
      input  value, setmax_x, setmax_y, setx, sety, ready, done
   );
endinterface

// File: rtl/mouse_setup_ctrl.sv
// Programs PS/2 mouse core bounds/centre after reset, then serves recentre/warp.
// Optional MOUSE_WARP_CLAMP_EN clamps captured warp targets to the screen.
module mouse_setup_ctrl #(
   parameter int SCREEN_W    = 1024,
   parameter int SCREEN_H    = 768,
   parameter int INIT_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic               clk,
   input  logic               rst,
   mouse_setup_ctrl_if.master bus
);

   localparam int CW = 16;
   localparam logic [11:0] MAX_X = 12'(SCREEN_W - 1);
   localparam logic [11:0] MAX_Y = 12'(SCREEN_H - 1);
   localparam logic [11:0] CEN_X = 12'(SCREEN_W / 2);
   localparam logic [11:0] CEN_Y = 12'(SCREEN_H / 2);

   typedef enum logic [2:0] {
      INIT, WR_MAXX, WR_MAXY, WR_X, WR_Y, GAP, IDLE
   } state_e;

   state_e state_q, state_d, nxt_q, nxt_d, tgt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic pend_q, pend_d, seq_q, seq_d;
   logic [11:0] px_q, px_d, py_q, py_d;
   logic [11:0] tx_q, tx_d, ty_q, ty_d;
   logic [11:0] value_q, value_d;
   logic smx_q, smx_d, smy_q, smy_d;
   logic sx_q, sx_d, sy_q, sy_d;
   logic ready_q, ready_d, done_q, done_d;
   logic adv, start, req_any;
   logic [11:0] warp_xc, warp_yc, req_x, req_y;

`ifdef MOUSE_WARP_CLAMP_EN
   assign warp_xc = (bus.warp_x > MAX_X) ? MAX_X : bus.warp_x;
   assign warp_yc = (bus.warp_y > MAX_Y) ? MAX_Y : bus.warp_y;
`else
   assign warp_xc = bus.warp_x;
   assign warp_yc = bus.warp_y;
`endif

   // Recentre wins over a simultaneous warp.
   assign req_any = bus.recenter_req | bus.warp_req;
   assign req_x   = bus.recenter_req ? CEN_X : warp_xc;
   assign req_y   = bus.recenter_req ? CEN_Y : warp_yc;

   always_comb begin
      state_d = state_q;
      nxt_d   = nxt_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      seq_d   = seq_q;
      px_d    = px_q;
      py_d    = py_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      value_d = value_q;
      done_d  = 1'b0;
      adv     = 1'b0;
      start   = 1'b0;
      tgt     = IDLE;

      unique case (state_q)
         INIT: begin
            if (cnt_q == CW'(INIT_CYCLES)) state_d = WR_MAXX;
            else cnt_d = cnt_q + CW'(1);
         end
         WR_MAXX: begin
            adv = 1'b1;
            tgt = WR_MAXY;
         end
         WR_MAXY: begin
            adv  = 1'b1;
            tgt  = WR_X;
            tx_d = CEN_X;
            ty_d = CEN_Y;
         end
         WR_X: begin
            adv = 1'b1;
            tgt = WR_Y;
         end
         WR_Y: begin
            adv = 1'b1;
            tgt = IDLE;
         end
         GAP: begin
            if (cnt_q + CW'(1) >= CW'(GAP_CYCLES)) state_d = nxt_q;
            else cnt_d = cnt_q + CW'(1);
         end
         IDLE: start = req_any | pend_q;
         default: state_d = INIT;
      endcase

      if (adv) begin
         if (GAP_CYCLES == 0) begin
            state_d = tgt;
         end else begin
            state_d = GAP;
            cnt_d   = '0;
            nxt_d   = tgt;
         end
      end

      // A fresh request beats a stale slot entry when both are present.
      if (start) begin
         state_d = WR_X;
         seq_d   = 1'b1;
         pend_d  = 1'b0;
         tx_d    = req_any ? req_x : px_q;
         ty_d    = req_any ? req_y : py_q;
      end else if (req_any) begin
         pend_d = 1'b1;
         px_d   = req_x;
         py_d   = req_y;
      end

      if (state_d == IDLE && state_q != IDLE) begin
         done_d = seq_q;
         seq_d  = 1'b0;
      end

      ready_d = (state_d == IDLE) && !pend_d;
      smx_d   = (state_d == WR_MAXX);
      smy_d   = (state_d == WR_MAXY);
      sx_d    = (state_d == WR_X);
      sy_d    = (state_d == WR_Y);

      unique case (state_d)
         WR_MAXX: value_d = MAX_X;
         WR_MAXY: value_d = MAX_Y;
         WR_X:    value_d = tx_d;
         WR_Y:    value_d = ty_d;
         default: value_d = value_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         nxt_q   <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         seq_q   <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         value_q <= '0;
         smx_q   <= 1'b0;
         smy_q   <= 1'b0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nxt_q   <= nxt_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         seq_q   <= seq_d;
         px_q    <= px_d;
         py_q    <= py_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         value_q <= value_d;
         smx_q   <= smx_d;
         smy_q   <= smy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign bus.value    = value_q;
   assign bus.setmax_x = smx_q;
   assign bus.setmax_y = smy_q;
   assign bus.setx     = sx_q;
   assign bus.sety     = sy_q;
   assign bus.ready    = ready_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_mouse_setup_ctrl.sv
// Directed bench for mouse_setup_ctrl at default parameters.
// Flags are {setmax_x, setmax_y, setx, sety, ready, done}.
module tb_mouse_setup_ctrl;

   localparam logic [5:0] Q  = 6'b000000;
   localparam logic [5:0] MX = 6'b100000;
   localparam logic [5:0] MY = 6'b010000;
   localparam logic [5:0] SX = 6'b001000;
   localparam logic [5:0] SY = 6'b000100;
   localparam logic [5:0] RD = 6'b000010;
   localparam logic [5:0] DN = 6'b000001;

`ifdef MOUSE_WARP_CLAMP_EN
   localparam logic [11:0] BIG_X = 12'd1023;
   localparam logic [11:0] BIG_Y = 12'd767;
`else
   localparam logic [11:0] BIG_X = 12'd4000;
   localparam logic [11:0] BIG_Y = 12'd900;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [5:0] fl;

   mouse_setup_ctrl_if bus ();

   mouse_setup_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign fl = {bus.setmax_x, bus.setmax_y, bus.setx,
                bus.sety, bus.ready, bus.done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // quiet edges with no outputs active, then one edge with flags f
   task automatic seq(input string tag, input int quiet,
                      input logic [5:0] f, input logic [11:0] v);
      for (int i = 0; i < quiet; i++) begin
         step();
         chk({tag, "_quiet"}, 32'(fl), 32'(Q));
      end
      step();
      chk({tag, "_flags"}, 32'(fl), 32'(f));
      chk({tag, "_value"}, 32'(bus.value), 32'(v));
   endtask

   task automatic run_init(input string tag);
      seq({tag, "_maxx"}, 4, MX, 12'd1023);
      seq({tag, "_maxy"}, 2, MY, 12'd767);
      seq({tag, "_x"}, 2, SX, 12'd512);
      seq({tag, "_y"}, 2, SY, 12'd384);
      seq({tag, "_rdy"}, 2, RD, 12'd384);
   endtask

   task automatic warp(input logic [11:0] x, input logic [11:0] y);
      bus.warp_req = 1'b1;
      bus.warp_x   = x;
      bus.warp_y   = y;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.recenter_req = 1'b0;
      bus.warp_req = 1'b0;
      bus.warp_x = '0;
      bus.warp_y = '0;

      step();
      step();
      chk("reset_flags", 32'(fl), 32'(Q));
      chk("reset_value", 32'(bus.value), 32'd0);

      rst = 1'b0;
      run_init("init");

      warp(12'd100, 12'd200);
      seq("warp_x", 0, SX, 12'd100);
      bus.warp_req = 1'b0;
      seq("warp_y", 2, SY, 12'd200);
      seq("warp_done", 2, RD | DN, 12'd200);
      seq("warp_after", 0, RD, 12'd200);

      warp(12'd5, 12'd5);
      bus.recenter_req = 1'b1;
      seq("both_x", 0, SX, 12'd512);
      bus.warp_req = 1'b0;
      bus.recenter_req = 1'b0;
      seq("both_y", 2, SY, 12'd384);
      seq("both_done", 2, RD | DN, 12'd384);
      seq("both_one_done", 0, RD, 12'd384);
      seq("both_idle", 0, RD, 12'd384);

      warp(12'd4000, 12'd900);
      seq("big_x", 0, SX, BIG_X);
      bus.warp_req = 1'b0;
      seq("big_y", 2, SY, BIG_Y);
      seq("big_done", 2, RD | DN, BIG_Y);

      warp(12'd100, 12'd200);
      seq("pend_x1", 0, SX, 12'd100);
      warp(12'd7, 12'd8);
      seq("pend_cap", 0, Q, 12'd100);
      bus.warp_req = 1'b0;
      warp(12'd999, 12'd999);
      bus.warp_req = 1'b0;
      seq("pend_y1", 1, SY, 12'd200);
      seq("pend_done1", 2, DN, 12'd200);
      seq("pend_x2", 0, SX, 12'd7);
      seq("pend_y2", 2, SY, 12'd8);
      seq("pend_done2", 2, RD | DN, 12'd8);

      // reset between setmax_y and setx with a pending warp in the slot
      rst = 1'b1;
      step();
      rst = 1'b0;
      seq("mid_maxx", 4, MX, 12'd1023);
      seq("mid_maxy", 2, MY, 12'd767);
      warp(12'd10, 12'd20);
      seq("mid_cap", 0, Q, 12'd767);
      bus.warp_req = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_rst_flags", 32'(fl), 32'(Q));
      end
      rst = 1'b0;
      run_init("reinit");
      for (int i = 0; i < 4; i++)
         seq("reinit_no_stale", 0, RD, 12'd384);

      // warp then recenter both during INIT
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("i4_e0", 32'(fl), 32'(Q));
      warp(12'd10, 12'd10);
      step();
      chk("i4_e1", 32'(fl), 32'(Q));
      bus.warp_req = 1'b0;
      bus.recenter_req = 1'b1;
      step();
      chk("i4_e2", 32'(fl), 32'(Q));
      bus.recenter_req = 1'b0;
      seq("i4_maxx", 1, MX, 12'd1023);
      seq("i4_maxy", 2, MY, 12'd767);
      seq("i4_x", 2, SX, 12'd512);
      seq("i4_y", 2, SY, 12'd384);
      seq("i4_x2", 3, SX, 12'd512);
      seq("i4_y2", 2, SY, 12'd384);
      seq("i4_done", 2, RD | DN, 12'd384);
      seq("i4_idle", 0, RD, 12'd384);
      seq("i4_idle2", 0, RD, 12'd384);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
